// File: rtl/kf_stage_responder.sv
// Responder side of the KF controller enable/done handshake: start pulses, held done
// levels, init-load gating, one-deep measurement buffer, iteration count and stage watchdog.
module kf_stage_responder #(
    parameter int DATA_W     = 32,
    parameter int MEAS_WORDS = 6,
    parameter int INIT_WORDS = 12,
    parameter int N_ITER     = 1024,
    parameter int TIMEOUT    = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_init,
    input  logic                          en_sp,
    input  logic                          en_ckg,
    input  logic                          en_scu,
    input  logic                          en_sco,
    input  logic                          finish,
    output logic                          Init_Valid,
    output logic                          SP_Done,
    output logic                          CKG_Done,
    output logic                          SCU_Done_s,
    output logic                          SCU_Done_p,
    output logic                          SCO_Valid,
    output logic                          MDI_Valid,
    output logic                          End_valid,
    input  logic                          init_wr_valid,
    output logic                          init_wr_ready,
    output logic                          sp_start,
    output logic                          ckg_start,
    output logic                          scu_s_start,
    output logic                          scu_p_start,
    input  logic                          sp_dp_done,
    input  logic                          ckg_dp_done,
    input  logic                          scu_s_dp_done,
    input  logic                          scu_p_dp_done,
    input  logic                          meas_valid,
    output logic                          meas_ready,
    input  logic [DATA_W-1:0]             meas_data,
    input  logic [$clog2(MEAS_WORDS)-1:0] meas_rd_addr,
    output logic [DATA_W-1:0]             meas_rd_data,
    output logic                          timeout_err
);

    localparam int ADDR_W = $clog2(MEAS_WORDS);
    localparam int INIT_W = $clog2(INIT_WORDS + 1);
    localparam int ITER_W = $clog2(N_ITER + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int NSTG   = 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEAS_WORDS - 1);

    // Enable edge detection
    logic en_init_q_reg, en_sp_q_reg, en_ckg_q_reg, en_scu_q_reg;
    logic rise_sp, rise_ckg, rise_scu;
    logic fall_init, fall_sp, fall_ckg, fall_scu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_init_q_reg <= 1'b0;
            en_sp_q_reg   <= 1'b0;
            en_ckg_q_reg  <= 1'b0;
            en_scu_q_reg  <= 1'b0;
        end else begin
            en_init_q_reg <= en_init;
            en_sp_q_reg   <= en_sp;
            en_ckg_q_reg  <= en_ckg;
            en_scu_q_reg  <= en_scu;
        end
    end

    assign rise_sp   = en_sp & ~en_sp_q_reg;
    assign rise_ckg  = en_ckg & ~en_ckg_q_reg;
    assign rise_scu  = en_scu & ~en_scu_q_reg;
    assign fall_init = ~en_init & en_init_q_reg;
    assign fall_sp   = ~en_sp & en_sp_q_reg;
    assign fall_ckg  = ~en_ckg & en_ckg_q_reg;
    assign fall_scu  = ~en_scu & en_scu_q_reg;

    // Stage lanes, index order: SP, CKG, SCU_s, SCU_p
    logic [NSTG-1:0] stg_en, stg_fall, stg_launch, stg_dp_done, stg_done, stg_expired;
    logic [NSTG-1:0] start_reg;

    assign stg_en      = {en_scu, en_scu, en_ckg, en_sp};
    assign stg_fall    = {fall_scu, fall_scu, fall_ckg, fall_sp};
    assign stg_launch  = {rise_scu, rise_scu, rise_ckg, rise_sp} & {NSTG{~finish}};
    assign stg_dp_done = {scu_p_dp_done, scu_s_dp_done, ckg_dp_done, sp_dp_done};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_reg <= '0;
        else        start_reg <= stg_launch;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_stage
            logic            done_reg;
            logic            active_reg;
            logic [TO_W-1:0] cnt_reg;
            logic            at_limit;

            assign at_limit = (cnt_reg == TO_W'(TIMEOUT - 1));

            // Enable fall clears before a coincident dp_done can set
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    done_reg <= 1'b0;
                end else if (!finish) begin
                    if (stg_fall[gi])                        done_reg <= 1'b0;
                    else if (stg_en[gi] && stg_dp_done[gi]) done_reg <= 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    active_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else if (stg_launch[gi]) begin
                    active_reg <= 1'b1;
                    cnt_reg    <= '0;
                end else if (active_reg) begin
                    if (stg_dp_done[gi] || stg_fall[gi] || at_limit) active_reg <= 1'b0;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign stg_done[gi]    = done_reg;
            assign stg_expired[gi] = active_reg & at_limit & ~stg_launch[gi]
                                   & ~stg_dp_done[gi] & ~stg_fall[gi];
        end
    endgenerate

    assign sp_start    = start_reg[0];
    assign ckg_start   = start_reg[1];
    assign scu_s_start = start_reg[2];
    assign scu_p_start = start_reg[3];
    assign SP_Done     = stg_done[0];
    assign CKG_Done    = stg_done[1];
    assign SCU_Done_s  = stg_done[2];
    assign SCU_Done_p  = stg_done[3];

    // Watchdog only reports; it never fakes a done
    logic timeout_err_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout_err_reg <= 1'b0;
        else        timeout_err_reg <= timeout_err_reg | (|stg_expired);
    end
    assign timeout_err = timeout_err_reg;

    logic sco_valid_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sco_valid_reg <= 1'b0;
        else if (!finish) sco_valid_reg <= en_sco & stg_done[2] & stg_done[3];
    end
    assign SCO_Valid = sco_valid_reg;

    // Init-load beat counting
    logic [INIT_W-1:0] init_cnt_reg;
    logic              init_valid_reg;
    logic              init_beat;

    assign init_wr_ready = en_init & ~init_valid_reg & ~finish;
    assign init_beat     = init_wr_valid & init_wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_reg   <= '0;
            init_valid_reg <= 1'b0;
        end else if (fall_init) begin
            init_cnt_reg   <= '0;
            init_valid_reg <= 1'b0;
        end else if (init_beat) begin
            if (init_cnt_reg == INIT_W'(INIT_WORDS - 1)) init_valid_reg <= 1'b1;
            init_cnt_reg <= init_cnt_reg + 1'b1;
        end
    end
    assign Init_Valid = init_valid_reg;

    // Completed update iterations, saturating
    logic [ITER_W-1:0] iter_cnt_reg;
    logic              iter_sat;

    assign iter_sat = (iter_cnt_reg == ITER_W'(N_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            iter_cnt_reg <= '0;
        else if (!finish && fall_scu && stg_done[2] && stg_done[3] && !iter_sat)
            iter_cnt_reg <= iter_cnt_reg + 1'b1;
    end
    assign End_valid = iter_sat;

    // Measurement buffer
    typedef enum logic {MEAS_FILL, MEAS_FULL} meas_state_t;
    meas_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] wptr_reg;
    logic              meas_beat;
    logic [DATA_W-1:0] meas_mem [MEAS_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= MEAS_FILL;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        meas_ready = 1'b0;
        MDI_Valid  = 1'b0;
        case (state_reg)
            MEAS_FILL: begin
                meas_ready = ~finish;
                if (meas_valid && !finish && wptr_reg == LAST_ADDR) state_next = MEAS_FULL;
            end
            MEAS_FULL: begin
                MDI_Valid = 1'b1;
                if (fall_scu && !finish) state_next = MEAS_FILL;
            end
            default: state_next = MEAS_FILL;
        endcase
    end

    assign meas_beat = meas_valid & meas_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wptr_reg <= '0;
        else if (meas_beat)
            wptr_reg <= (wptr_reg == LAST_ADDR) ? '0 : wptr_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (meas_beat) meas_mem[wptr_reg] <= meas_data;
    end

    assign meas_rd_data = (meas_rd_addr <= LAST_ADDR) ? meas_mem[meas_rd_addr] : '0;

endmodule

// File: tb/tb_kf_stage_responder.sv
// Directed bench for kf_stage_responder; short N_ITER/TIMEOUT so iteration and watchdog paths finish quickly.
module tb_kf_stage_responder;

    localparam int DATA_W     = 32;
    localparam int MEAS_WORDS = 6;
    localparam int INIT_WORDS = 12;
    localparam int N_ITER     = 4;
    localparam int TIMEOUT    = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic en_init, en_sp, en_ckg, en_scu, en_sco, finish;
    logic Init_Valid, SP_Done, CKG_Done, SCU_Done_s, SCU_Done_p, SCO_Valid, MDI_Valid, End_valid;
    logic init_wr_valid, init_wr_ready;
    logic sp_start, ckg_start, scu_s_start, scu_p_start;
    logic sp_dp_done, ckg_dp_done, scu_s_dp_done, scu_p_dp_done;
    logic meas_valid, meas_ready;
    logic [DATA_W-1:0] meas_data, meas_rd_data;
    logic [2:0] meas_rd_addr;
    logic timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kf_stage_responder #(
        .DATA_W(DATA_W), .MEAS_WORDS(MEAS_WORDS), .INIT_WORDS(INIT_WORDS),
        .N_ITER(N_ITER), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .en_init(en_init), .en_sp(en_sp), .en_ckg(en_ckg), .en_scu(en_scu),
        .en_sco(en_sco), .finish(finish),
        .Init_Valid(Init_Valid), .SP_Done(SP_Done), .CKG_Done(CKG_Done),
        .SCU_Done_s(SCU_Done_s), .SCU_Done_p(SCU_Done_p), .SCO_Valid(SCO_Valid),
        .MDI_Valid(MDI_Valid), .End_valid(End_valid),
        .init_wr_valid(init_wr_valid), .init_wr_ready(init_wr_ready),
        .sp_start(sp_start), .ckg_start(ckg_start),
        .scu_s_start(scu_s_start), .scu_p_start(scu_p_start),
        .sp_dp_done(sp_dp_done), .ckg_dp_done(ckg_dp_done),
        .scu_s_dp_done(scu_s_dp_done), .scu_p_dp_done(scu_p_dp_done),
        .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_data(meas_data),
        .meas_rd_addr(meas_rd_addr), .meas_rd_data(meas_rd_data),
        .timeout_err(timeout_err)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] got;
        rst_n = 1'b0;
        {en_init, en_sp, en_ckg, en_scu, en_sco, finish} = '0;
        {init_wr_valid, sp_dp_done, ckg_dp_done, scu_s_dp_done, scu_p_dp_done, meas_valid} = '0;
        meas_data = '0;
        meas_rd_addr = '0;
        repeat (3) step();
        got = {Init_Valid, SP_Done, CKG_Done, SCU_Done_s, SCU_Done_p, SCO_Valid, MDI_Valid,
               End_valid, init_wr_ready, sp_start, ckg_start, scu_s_start, scu_p_start,
               timeout_err, meas_ready};
        checks++;
        if (got !== 15'b000000000000001) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", got, 15'b000000000000001);
        end
        rst_n = 1'b1;
        step();
        got = {Init_Valid, SP_Done, CKG_Done, SCU_Done_s, SCU_Done_p, SCO_Valid, MDI_Valid,
               End_valid, init_wr_ready, sp_start, ckg_start, scu_s_start, scu_p_start,
               timeout_err, meas_ready};
        checks++;
        if (got !== 15'b000000000000001) begin
            errors++;
            $display("FAIL post_reset_outputs got %b exp %b", got, 15'b000000000000001);
        end
        $display("reset: outputs idle, meas_ready=%b", meas_ready);
    endtask

    task automatic test_init();
        int accepted = 0;
        en_init = 1'b1;
        init_wr_valid = 1'b1;
        #1;
        for (int i = 0; i < INIT_WORDS; i++) begin
            checks++;
            if (init_wr_ready !== 1'b1 || Init_Valid !== 1'b0) begin
                errors++;
                $display("FAIL init_beat%0d ready=%b valid=%b exp ready=1 valid=0",
                         i, init_wr_ready, Init_Valid);
            end
            if (init_wr_ready === 1'b1) accepted++;
            step();
        end
        checks++;
        if (Init_Valid !== 1'b1 || init_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_done valid=%b ready=%b exp valid=1 ready=0", Init_Valid, init_wr_ready);
        end
        step();
        checks++;
        if (Init_Valid !== 1'b1 || init_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_hold valid=%b ready=%b exp valid=1 ready=0", Init_Valid, init_wr_ready);
        end
        en_init = 1'b0;
        init_wr_valid = 1'b0;
        step();
        checks++;
        if (Init_Valid !== 1'b0) begin
            errors++;
            $display("FAIL init_clear valid=%b exp 0", Init_Valid);
        end
        $display("init: %0d beats accepted, Init_Valid cleared on en_init fall", accepted);
    endtask

    task automatic test_sp();
        en_sp = 1'b1;
        #1;
        checks++;
        if (sp_start !== 1'b0) begin
            errors++;
            $display("FAIL sp_start_t0 got %b exp 0", sp_start);
        end
        step();
        checks++;
        if (sp_start !== 1'b1) begin
            errors++;
            $display("FAIL sp_start_t1 got %b exp 1", sp_start);
        end
        step();
        checks++;
        if (sp_start !== 1'b0) begin
            errors++;
            $display("FAIL sp_start_t2 got %b exp 0", sp_start);
        end
        repeat (3) step();
        sp_dp_done = 1'b1;
        #1;
        checks++;
        if (SP_Done !== 1'b0) begin
            errors++;
            $display("FAIL sp_done_t5 got %b exp 0", SP_Done);
        end
        step();
        sp_dp_done = 1'b0;
        checks++;
        if (SP_Done !== 1'b1) begin
            errors++;
            $display("FAIL sp_done_t6 got %b exp 1", SP_Done);
        end
        repeat (3) step();
        checks++;
        if (SP_Done !== 1'b1) begin
            errors++;
            $display("FAIL sp_done_hold got %b exp 1", SP_Done);
        end
        en_sp = 1'b0;
        step();
        checks++;
        if (SP_Done !== 1'b0) begin
            errors++;
            $display("FAIL sp_done_clear got %b exp 0", SP_Done);
        end
        sp_dp_done = 1'b1;
        step();
        sp_dp_done = 1'b0;
        step();
        checks++;
        if (SP_Done !== 1'b0) begin
            errors++;
            $display("FAIL sp_done_en_low got %b exp 0", SP_Done);
        end
        $display("sp: start pulse and done level sequence observed");
    endtask

    task automatic test_meas();
        logic [DATA_W-1:0] exp_word;
        for (int i = 0; i < MEAS_WORDS; i++) begin
            meas_valid = 1'b1;
            meas_data = 32'hC0DE_0000 + 32'(i * 17);
            #1;
            checks++;
            if (meas_ready !== 1'b1) begin
                errors++;
                $display("FAIL meas_ready_beat%0d got %b exp 1", i, meas_ready);
            end
            step();
        end
        meas_valid = 1'b0;
        #1;
        checks++;
        if (MDI_Valid !== 1'b1 || meas_ready !== 1'b0) begin
            errors++;
            $display("FAIL meas_full mdi=%b ready=%b exp mdi=1 ready=0", MDI_Valid, meas_ready);
        end
        meas_valid = 1'b1;
        meas_data = 32'hDEAD_BEEF;
        step();
        meas_valid = 1'b0;
        for (int i = 0; i < MEAS_WORDS; i++) begin
            meas_rd_addr = 3'(i);
            exp_word = 32'hC0DE_0000 + 32'(i * 17);
            #1;
            checks++;
            if (meas_rd_data !== exp_word) begin
                errors++;
                $display("FAIL meas_rd%0d got %h exp %h", i, meas_rd_data, exp_word);
            end
        end
        en_scu = 1'b1;
        step();
        step();
        en_scu = 1'b0;
        #1;
        checks++;
        if (MDI_Valid !== 1'b1) begin
            errors++;
            $display("FAIL meas_full_until_edge mdi=%b exp 1", MDI_Valid);
        end
        step();
        checks++;
        if (MDI_Valid !== 1'b0 || meas_ready !== 1'b1) begin
            errors++;
            $display("FAIL meas_consumed mdi=%b ready=%b exp mdi=0 ready=1", MDI_Valid, meas_ready);
        end
        $display("meas: buffer filled, read back, released on en_scu fall");
    endtask

    task automatic test_scu_sco();
        en_sco = 1'b1;
        en_scu = 1'b1;
        step();
        checks++;
        if (scu_s_start !== 1'b1 || scu_p_start !== 1'b1) begin
            errors++;
            $display("FAIL scu_starts s=%b p=%b exp 1 1", scu_s_start, scu_p_start);
        end
        step();
        scu_p_dp_done = 1'b1;
        step();
        scu_p_dp_done = 1'b0;
        checks++;
        if (SCU_Done_p !== 1'b1 || SCU_Done_s !== 1'b0 || SCO_Valid !== 1'b0) begin
            errors++;
            $display("FAIL scu_p_only p=%b s=%b sco=%b exp 1 0 0", SCU_Done_p, SCU_Done_s, SCO_Valid);
        end
        repeat (3) step();
        scu_s_dp_done = 1'b1;
        step();
        scu_s_dp_done = 1'b0;
        checks++;
        if (SCU_Done_s !== 1'b1 || SCO_Valid !== 1'b0) begin
            errors++;
            $display("FAIL scu_both_lag s=%b sco=%b exp 1 0", SCU_Done_s, SCO_Valid);
        end
        step();
        checks++;
        if (SCO_Valid !== 1'b1) begin
            errors++;
            $display("FAIL sco_valid got %b exp 1", SCO_Valid);
        end
        en_sco = 1'b0;
        step();
        checks++;
        if (SCO_Valid !== 1'b0) begin
            errors++;
            $display("FAIL sco_drop got %b exp 0", SCO_Valid);
        end
        en_scu = 1'b0;
        step();
        checks++;
        if (SCU_Done_s !== 1'b0 || SCU_Done_p !== 1'b0 || End_valid !== 1'b0) begin
            errors++;
            $display("FAIL scu_clear s=%b p=%b end=%b exp 0 0 0", SCU_Done_s, SCU_Done_p, End_valid);
        end
        $display("scu/sco: SCO_Valid after both dones, iteration 1 complete");
    endtask

    task automatic run_loop();
        en_sp = 1'b1;
        step(); step();
        sp_dp_done = 1'b1;
        step();
        sp_dp_done = 1'b0;
        en_sp = 1'b0;
        step();
        en_ckg = 1'b1;
        step(); step();
        ckg_dp_done = 1'b1;
        step();
        ckg_dp_done = 1'b0;
        en_ckg = 1'b0;
        step();
        en_scu = 1'b1;
        step(); step();
        scu_s_dp_done = 1'b1;
        scu_p_dp_done = 1'b1;
        step();
        scu_s_dp_done = 1'b0;
        scu_p_dp_done = 1'b0;
        step();
        en_scu = 1'b0;
        step();
    endtask

    task automatic test_iterations();
        logic exp_end;
        for (int k = 2; k <= N_ITER + 1; k++) begin
            run_loop();
            exp_end = (k >= N_ITER);
            checks++;
            if (End_valid !== exp_end) begin
                errors++;
                $display("FAIL end_valid_iter%0d got %b exp %b", k, End_valid, exp_end);
            end
            $display("iteration %0d: End_valid=%b", k, End_valid);
        end
        repeat (5) step();
        checks++;
        if (End_valid !== 1'b1) begin
            errors++;
            $display("FAIL end_valid_hold got %b exp 1", End_valid);
        end
    endtask

    task automatic test_finish();
        finish = 1'b1;
        en_sp = 1'b1;
        #1;
        checks++;
        if (meas_ready !== 1'b0) begin
            errors++;
            $display("FAIL finish_meas_ready got %b exp 0", meas_ready);
        end
        step();
        checks++;
        if (sp_start !== 1'b0) begin
            errors++;
            $display("FAIL finish_no_start got %b exp 0", sp_start);
        end
        sp_dp_done = 1'b1;
        step();
        sp_dp_done = 1'b0;
        checks++;
        if (SP_Done !== 1'b0) begin
            errors++;
            $display("FAIL finish_frozen_done got %b exp 0", SP_Done);
        end
        en_sp = 1'b0;
        step();
        finish = 1'b0;
        step();
        $display("finish: starts suppressed, meas_ready low, levels frozen");
    endtask

    task automatic test_timeout_reset();
        en_ckg = 1'b1;
        step();
        checks++;
        if (ckg_start !== 1'b1) begin
            errors++;
            $display("FAIL ckg_start got %b exp 1", ckg_start);
        end
        repeat (TIMEOUT - 2) step();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got %b exp 0", timeout_err);
        end
        repeat (4) step();
        checks++;
        if (timeout_err !== 1'b1 || CKG_Done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_set err=%b ckg_done=%b exp 1 0", timeout_err, CKG_Done);
        end
        repeat (10) step();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got %b exp 1", timeout_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (timeout_err !== 1'b0 || End_valid !== 1'b0 || CKG_Done !== 1'b0 ||
            MDI_Valid !== 1'b0 || meas_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset err=%b end=%b ckg=%b mdi=%b ready=%b exp 0 0 0 0 1",
                     timeout_err, End_valid, CKG_Done, MDI_Valid, meas_ready);
        end
        en_ckg = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (timeout_err !== 1'b0 || End_valid !== 1'b0 || ckg_start !== 1'b0) begin
            errors++;
            $display("FAIL after_reset err=%b end=%b ckg_start=%b exp 0 0 0",
                     timeout_err, End_valid, ckg_start);
        end
        $display("timeout: flag raised without forcing done, cleared by reset");
    endtask

    initial begin
        test_reset();
        test_init();
        test_sp();
        test_meas();
        test_scu_sco();
        test_iterations();
        test_finish();
        test_timeout_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
